// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle: master requests/targets, slave readiness,
// and the arbiter's grant/select outputs.
//   master modport : the side that drives requests and observes grants
//   slave  modport : the arbiter's view of the bundle
interface bus_arbiter_if;
  logic       m1_req;
  logic       m2_req;
  logic [1:0] m1_slave_sel;
  logic [1:0] m2_slave_sel;
  logic [2:0] slave_ready;
  logic       m1_grant;
  logic       m2_grant;
  logic       msel;
  logic [1:0] ssel;
  logic [2:0] slave_en;
  logic       bus_busy;
  logic       timeout_flag;

  modport master (
    output m1_req, m2_req, m1_slave_sel, m2_slave_sel, slave_ready,
    input  m1_grant, m2_grant, msel, ssel, slave_en, bus_busy, timeout_flag
  );

  modport slave (
    input  m1_req, m2_req, m1_slave_sel, m2_slave_sel, slave_ready,
    output m1_grant, m2_grant, msel, ssel, slave_en, bus_busy, timeout_flag
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / three-slave grant controller for the shared system bus.
// A master is granted only when its target slave is ready; the grant is
// held until the master drops its request or the hold timeout expires,
// followed by one RELEASE turnaround cycle.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN -- alternate grants on
// contention; when undefined master 1 has fixed priority.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT_M1, GRANT_M2, RELEASE} state_t;

  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;   // 0 = master 1, 1 = master 2
  logic             lock1, lock2; // set on timeout, cleared while req is low
  logic             elig1, elig2, pick2, cur_req;
  logic [3:0]       rdy_x;

  // Eligibility and tie-break; index 3 maps to a permanently-unready slot
  always_comb begin
    rdy_x = {1'b0, bus.slave_ready};
    elig1 = bus.m1_req && (bus.m1_slave_sel != 2'd3) &&
            rdy_x[bus.m1_slave_sel] && !lock1;
    elig2 = bus.m2_req && (bus.m2_slave_sel != 2'd3) &&
            rdy_x[bus.m2_slave_sel] && !lock2;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    pick2 = elig2 && (!elig1 || (last_grant == 1'b0));
`else
    pick2 = elig2 && !elig1;
`endif
    cur_req = (state == GRANT_M2) ? bus.m2_req : bus.m1_req;
  end

`ifndef BUS_ARB_ROUND_ROBIN_EN
  // last_grant is tracked in both builds but only steers round-robin
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Arbitration FSM with registered outputs; reset drops any grant at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      lock1        <= 1'b0;
      lock2        <= 1'b0;
      bus.m1_grant     <= 1'b0;
      bus.m2_grant     <= 1'b0;
      bus.msel         <= 1'b0;
      bus.ssel         <= 2'd0;
      bus.slave_en     <= 3'b000;
      bus.bus_busy     <= 1'b0;
      bus.timeout_flag <= 1'b0;
    end else begin
      if (!bus.m1_req) lock1 <= 1'b0;
      if (!bus.m2_req) lock2 <= 1'b0;

      case (state)
        IDLE: begin
          if (pick2) begin
            state        <= GRANT_M2;
            bus.m2_grant <= 1'b1;
            bus.msel     <= 1'b1;
            bus.ssel     <= bus.m2_slave_sel;
            bus.slave_en <= 3'b001 << bus.m2_slave_sel;
            bus.bus_busy <= 1'b1;
            last_grant   <= 1'b1;
            cnt          <= '0;
          end else if (elig1) begin
            state        <= GRANT_M1;
            bus.m1_grant <= 1'b1;
            bus.msel     <= 1'b0;
            bus.ssel     <= bus.m1_slave_sel;
            bus.slave_en <= 3'b001 << bus.m1_slave_sel;
            bus.bus_busy <= 1'b1;
            last_grant   <= 1'b0;
            cnt          <= '0;
          end
        end

        GRANT_M1, GRANT_M2: begin
          // A request drop wins over a coincident timeout: plain release
          if (!cur_req) begin
            state        <= RELEASE;
            bus.m1_grant <= 1'b0;
            bus.m2_grant <= 1'b0;
            bus.slave_en <= 3'b000;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            state            <= RELEASE;
            bus.m1_grant     <= 1'b0;
            bus.m2_grant     <= 1'b0;
            bus.slave_en     <= 3'b000;
            bus.timeout_flag <= 1'b1;
            if (state == GRANT_M1) lock1 <= 1'b1;
            else                   lock2 <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          state            <= IDLE;
          bus.bus_busy     <= 1'b0;
          bus.timeout_flag <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter. Instance u_a uses the
// default timeout; u_b uses TIMEOUT=4 for the hold-timeout scenarios.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  bus_arbiter_if a ();
  bus_arbiter_if b ();

  bus_arbiter u_a (.clk(clk), .reset(reset), .bus(a.slave));
  bus_arbiter #(.TIMEOUT(4), .CNT_W(3)) u_b (.clk(clk), .reset(reset), .bus(b.slave));

  // Free-running bus clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected-output packer: {m1_grant, m2_grant, msel, ssel, slave_en, bus_busy, timeout_flag}
  function automatic logic [9:0] o(input logic g1, input logic g2, input logic ms,
                                   input logic [1:0] ss, input logic [2:0] en,
                                   input logic bz, input logic to);
    return {g1, g2, ms, ss, en, bz, to};
  endfunction

  function automatic logic [9:0] oa();
    return {a.m1_grant, a.m2_grant, a.msel, a.ssel, a.slave_en, a.bus_busy, a.timeout_flag};
  endfunction

  function automatic logic [9:0] ob();
    return {b.m1_grant, b.m2_grant, b.msel, b.ssel, b.slave_en, b.bus_busy, b.timeout_flag};
  endfunction

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp2;
    a.m1_req = 0; a.m2_req = 0; a.m1_slave_sel = 0; a.m2_slave_sel = 0; a.slave_ready = 0;
    b.m1_req = 0; b.m2_req = 0; b.m1_slave_sel = 0; b.m2_slave_sel = 0; b.slave_ready = 0;

    // Reset held with both masters requesting
    reset = 1'b0;
    a.m1_req = 1; a.m2_req = 1; a.m1_slave_sel = 0; a.m2_slave_sel = 1; a.slave_ready = 3'b111;
    repeat (3) begin
      tick();
      chk("reset_a", oa(), 10'd0);
    end
    chk("reset_b", ob(), 10'd0);

    reset = 1'b1;
    tick();
    chk("first_grant", oa(), o(1, 0, 0, 2'd0, 3'b001, 1, 0));
    a.m1_req = 0; a.m2_req = 0;
    tick();
    chk("rel1", oa(), o(0, 0, 0, 2'd0, 3'b000, 1, 0));
    tick();
    chk("idle1", oa(), o(0, 0, 0, 2'd0, 3'b000, 0, 0));

    // Single master 2 to slave 2
    a.m2_req = 1; a.m2_slave_sel = 2; a.slave_ready = 3'b100;
    tick();
    chk("m2_grant", oa(), o(0, 1, 1, 2'd2, 3'b100, 1, 0));
    tick();
    chk("m2_hold", oa(), o(0, 1, 1, 2'd2, 3'b100, 1, 0));
    a.m2_req = 0;
    tick();
    chk("m2_rel", oa(), o(0, 0, 1, 2'd2, 3'b000, 1, 0));
    tick();
    chk("m2_idle", oa(), o(0, 0, 1, 2'd2, 3'b000, 0, 0));

    // Target slave not ready: no grant
    a.m1_req = 1; a.m1_slave_sel = 1; a.slave_ready = 3'b101;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("not_ready", oa(), o(0, 0, 1, 2'd2, 3'b000, 0, 0));
    end
    a.slave_ready = 3'b111;
    tick();
    chk("ready_grant", oa(), o(1, 0, 0, 2'd1, 3'b010, 1, 0));

    // Mid-grant: select change and ready loss are ignored
    a.m1_slave_sel = 2; a.slave_ready = 3'b000;
    tick();
    chk("sel_frozen", oa(), o(1, 0, 0, 2'd1, 3'b010, 1, 0));
    tick();
    chk("sel_frozen2", oa(), o(1, 0, 0, 2'd1, 3'b010, 1, 0));

    // Asynchronous reset mid-grant
    reset = 1'b0;
    #1;
    chk("async_rst", oa(), 10'd0);
    a.m1_req = 0;
    tick();
    reset = 1'b1;

    // Contention: four back-to-back 5-cycle transactions
    a.m1_slave_sel = 0; a.m2_slave_sel = 1; a.slave_ready = 3'b111;
    a.m1_req = 1; a.m2_req = 1;
    for (int t = 0; t < 4; t++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      exp2 = (t % 2) == 1;
`else
      exp2 = 1'b0;
`endif
      tick();
      chk($sformatf("cont%0d_grant", t), {8'd0, a.m1_grant, a.m2_grant}, exp2 ? 10'd1 : 10'd2);
      repeat (4) tick();
      chk($sformatf("cont%0d_hold", t), {8'd0, a.m1_grant, a.m2_grant}, exp2 ? 10'd1 : 10'd2);
      if (exp2) a.m2_req = 0; else a.m1_req = 0;
      tick();
      chk($sformatf("cont%0d_rel", t), {7'd0, a.m1_grant, a.m2_grant, a.bus_busy}, 10'd1);
      if (exp2) a.m2_req = 1; else a.m1_req = 1;
      tick();
      chk($sformatf("cont%0d_idle", t), {7'd0, a.m1_grant, a.m2_grant, a.bus_busy}, 10'd0);
    end
    a.m1_req = 0; a.m2_req = 0;
    tick();
    tick();

    // Timeout (TIMEOUT=4) with master 1 holding its request
    b.m1_req = 1; b.m2_req = 1; b.m1_slave_sel = 0; b.m2_slave_sel = 1; b.slave_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_grant", ob(), o(1, 0, 0, 2'd0, 3'b001, 1, 0));
    end
    tick();
    chk("to_flag", ob(), o(0, 0, 0, 2'd0, 3'b000, 1, 1));
    tick();
    chk("to_flag_clr", ob(), o(0, 0, 0, 2'd0, 3'b000, 0, 0));
    tick();
    chk("to_m2", ob(), o(0, 1, 1, 2'd1, 3'b010, 1, 0));
    b.m2_req = 0;
    tick();
    tick();
    tick();
    chk("lockout", ob(), o(0, 0, 1, 2'd1, 3'b000, 0, 0));
    tick();
    chk("lockout2", ob(), o(0, 0, 1, 2'd1, 3'b000, 0, 0));
    b.m1_req = 0;
    tick();
    b.m1_req = 1;
    tick();
    chk("regrant", ob(), o(1, 0, 0, 2'd0, 3'b001, 1, 0));

    // Request dropped on the timeout edge: normal release, no flag
    repeat (3) tick();
    b.m1_req = 0;
    tick();
    chk("to_vs_drop", ob(), o(0, 0, 0, 2'd0, 3'b000, 1, 0));
    tick();
    chk("to_vs_drop_idle", ob(), o(0, 0, 0, 2'd0, 3'b000, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
